dmg_timer_regs: RTL and testbench

//  CPU-facing end of the divider/timer path: owns DIV (FF04), TIMA (FF05), TMA (FF06), TAC (FF07).

---
 rtl/dmg_timer_regs_pkg.sv | 32 +++
 rtl/dmg_timer_regs_tap_sel.sv | 28 ++
 rtl/dmg_timer_regs.sv | 114 +++++++++++
 tb/tb_dmg_timer_regs.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmg_timer_regs_pkg.sv
// rtl/dmg_timer_regs_pkg.sv - shared constants, TAC encodings and reload FSM states for the DMG timer
package dmg_timer_regs_pkg;

  localparam logic [1:0] ADDR_DIV  = 2'd0;
  localparam logic [1:0] ADDR_TIMA = 2'd1;
  localparam logic [1:0] ADDR_TMA  = 2'd2;
  localparam logic [1:0] ADDR_TAC  = 2'd3;

  localparam logic [1:0] TAC_SEL_4096   = 2'b00;
  localparam logic [1:0] TAC_SEL_262144 = 2'b01;
  localparam logic [1:0] TAC_SEL_65536  = 2'b10;
  localparam logic [1:0] TAC_SEL_16384  = 2'b11;

  localparam logic [7:0] TAC_RD_MASK = 8'hF8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OVF    = 2'd1,
    ST_RELOAD = 2'd2
  } reload_state_e;

  // Odd counter bits are packed as {cnt[7], cnt[5], cnt[3], cnt[1]}; returns the slot for a select code.
  function automatic logic [1:0] tap_slot(input logic [1:0] sel);
    unique case (sel)
      TAC_SEL_4096:   tap_slot = 2'd3;
      TAC_SEL_262144: tap_slot = 2'd0;
      TAC_SEL_65536:  tap_slot = 2'd1;
      default:        tap_slot = 2'd2;
    endcase
  endfunction

endpackage

// File: rtl/dmg_timer_regs_tap_sel.sv
// rtl/dmg_timer_regs_tap_sel.sv - selects the TIMA divider tap and flags its falling edge
// Fed with the post-update TAC and counter so DIV/TAC writes can produce the DMG glitch increment.
module dmg_timer_tap_sel
  import dmg_timer_regs_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] tac_d,
  input  logic [3:0] cnt_odd_d,
  output logic       tap_fall
);

  logic tap;
  logic prev_tap_q, prev_tap_d;

  assign tap        = tac_d[2] & cnt_odd_d[tap_slot(tac_d[1:0])];
  assign prev_tap_d = tap;
  assign tap_fall   = prev_tap_q & ~tap;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_tap_q <= 1'b0;
    end else begin
      prev_tap_q <= prev_tap_d;
    end
  end

endmodule

// File: rtl/dmg_timer_regs.sv
// rtl/dmg_timer_regs.sv - DIV/TIMA/TMA/TAC register block with TIMA reload FSM and timer interrupt
module dmg_timer_regs
  import dmg_timer_regs_pkg::*;
#(
  parameter int CNT_BITS = 14,
  parameter int T_Q      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_sel,
  input  logic [1:0] cpu_addr,
  input  logic       cpu_wr,
  input  logic       cpu_rd,
  input  logic [7:0] cpu_wdata,
  output logic [7:0] cpu_rdata,
  output logic       irq_timer,
  output logic [5:0] div_taps
);

  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [7:0]          tima_q, tima_d;
  logic [7:0]          tma_q, tma_d;
  logic [2:0]          tac_q, tac_d;
  reload_state_e       state_q, state_d;

  logic       wr_div, wr_tima, wr_tma, wr_tac;
  logic       tap_fall;
  logic [7:0] tima_base;
  logic [8:0] tima_sum;
  logic       unused_tq;

  assign unused_tq = ^T_Q;

  assign wr_div  = cpu_sel & cpu_wr & (cpu_addr == ADDR_DIV);
  assign wr_tima = cpu_sel & cpu_wr & (cpu_addr == ADDR_TIMA);
  assign wr_tma  = cpu_sel & cpu_wr & (cpu_addr == ADDR_TMA);
  assign wr_tac  = cpu_sel & cpu_wr & (cpu_addr == ADDR_TAC);

  always_comb begin
    cnt_d = wr_div ? '0 : cnt_q + CNT_BITS'(1);
    tma_d = wr_tma ? cpu_wdata : tma_q;
    tac_d = wr_tac ? cpu_wdata[2:0] : tac_q;
  end

  dmg_timer_tap_sel u_tap_sel (
    .clk       (clk),
    .reset     (reset),
    .tac_d     (tac_d),
    .cnt_odd_d ({cnt_d[7], cnt_d[5], cnt_d[3], cnt_d[1]}),
    .tap_fall  (tap_fall)
  );

  // The stored value is settled first (write, reload or hold); a tap edge then increments it.
  always_comb begin
    state_d   = ST_IDLE;
    tima_base = tima_q;
    unique case (state_q)
      ST_IDLE: begin
        if (wr_tima) tima_base = cpu_wdata;
      end
      ST_OVF: begin
        if (wr_tima) begin
          tima_base = cpu_wdata;
        end else begin
          tima_base = tma_d;
          state_d   = ST_RELOAD;
        end
      end
      ST_RELOAD: begin
        // TIMA keeps tracking TMA during the reload cycle; direct TIMA writes are lost.
        if (wr_tma) tima_base = cpu_wdata;
      end
      default: ;
    endcase
    tima_sum = {1'b0, tima_base} + 9'd1;
    tima_d   = tima_base;
    if (tap_fall) begin
      tima_d = tima_sum[7:0];
      if (tima_sum[8]) state_d = ST_OVF;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      tima_q  <= 8'h00;
      tma_q   <= 8'h00;
      tac_q   <= 3'b000;
      state_q <= ST_IDLE;
    end else begin
      cnt_q   <= cnt_d;
      tima_q  <= tima_d;
      tma_q   <= tma_d;
      tac_q   <= tac_d;
      state_q <= state_d;
    end
  end

  assign irq_timer = (state_q == ST_RELOAD);
  assign div_taps  = cnt_q[7:2];

  always_comb begin
    cpu_rdata = 8'hFF;
    if (cpu_sel && cpu_rd) begin
      unique case (cpu_addr)
        ADDR_DIV:  cpu_rdata = cnt_q[CNT_BITS-1 -: 8];
        ADDR_TIMA: cpu_rdata = tima_q;
        ADDR_TMA:  cpu_rdata = tma_q;
        default:   cpu_rdata = TAC_RD_MASK | {5'b00000, tac_q};
      endcase
    end
  end

endmodule

// File: tb/tb_dmg_timer_regs.sv
// tb/tb_dmg_timer_regs.sv - directed bench for dmg_timer_regs: register table plus timer corner sequences
module tb_dmg_timer_regs;

  logic       clk = 1'b0;
  logic       reset;
  logic       cpu_sel;
  logic [1:0] cpu_addr;
  logic       cpu_wr;
  logic       cpu_rd;
  logic [7:0] cpu_wdata;
  logic [7:0] cpu_rdata;
  logic       irq_timer;
  logic [5:0] div_taps;

  int errors = 0;
  int checks = 0;
  int irq_cnt = 0;
  int irq_consec = 0;
  logic irq_prev = 1'b0;

  dmg_timer_regs dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_sel   (cpu_sel),
    .cpu_addr  (cpu_addr),
    .cpu_wr    (cpu_wr),
    .cpu_rd    (cpu_rd),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .irq_timer (irq_timer),
    .div_taps  (div_taps)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (irq_timer) irq_cnt <= irq_cnt + 1;
    if (irq_timer && irq_prev) irq_consec <= irq_consec + 1;
    irq_prev <= irq_timer;
  end

  typedef struct {
    logic       do_wr;
    logic       wr_sel;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_sel;
    logic       rd_en;
    logic [1:0] rd_addr;
    logic [7:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[9];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d, input logic sel);
    cpu_sel   = sel;
    cpu_wr    = 1'b1;
    cpu_addr  = a;
    cpu_wdata = d;
    step();
    cpu_wr  = 1'b0;
    cpu_sel = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic sel, input logic en, output logic [7:0] v);
    cpu_sel  = sel;
    cpu_rd   = en;
    cpu_addr = a;
    #1;
    v       = cpu_rdata;
    cpu_sel = 1'b0;
    cpu_rd  = 1'b0;
  endtask

  task automatic chk(input string n, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", n, got, exp);
    end
  endtask

  task automatic chk_reg(input string n, input logic [1:0] a, input logic [7:0] exp);
    logic [7:0] v;
    rd(a, 1'b1, 1'b1, v);
    chk(n, v, exp);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    bit found;

    vecs[0] = '{1'b1, 1'b1, 2'd2, 8'h5A, 1'b1, 1'b1, 2'd2, 8'h5A, "tbl_tma_rw"};
    vecs[1] = '{1'b1, 1'b1, 2'd1, 8'hC3, 1'b1, 1'b1, 2'd1, 8'hC3, "tbl_tima_rw"};
    vecs[2] = '{1'b1, 1'b1, 2'd3, 8'h03, 1'b1, 1'b1, 2'd3, 8'hFB, "tbl_tac_rw"};
    vecs[3] = '{1'b1, 1'b0, 2'd2, 8'h77, 1'b1, 1'b1, 2'd2, 8'h5A, "tbl_wr_nosel"};
    vecs[4] = '{1'b1, 1'b1, 2'd3, 8'hF8, 1'b1, 1'b1, 2'd3, 8'hF8, "tbl_tac_clr"};
    vecs[5] = '{1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 2'd1, 8'hFF, "tbl_rd_off"};
    vecs[6] = '{1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 2'd1, 8'hFF, "tbl_rd_nosel"};
    vecs[7] = '{1'b1, 1'b1, 2'd1, 8'h00, 1'b1, 1'b1, 2'd1, 8'h00, "tbl_tima_zero"};
    vecs[8] = '{1'b1, 1'b1, 2'd0, 8'h9C, 1'b1, 1'b1, 2'd0, 8'h00, "tbl_div_clr"};

    cpu_sel = 1'b0; cpu_addr = 2'd0; cpu_wr = 1'b0; cpu_rd = 1'b0; cpu_wdata = 8'h00;
    reset = 1'b1;
    repeat (3) step();
    chk_reg("rst_div", 2'd0, 8'h00);
    chk_reg("rst_tima", 2'd1, 8'h00);
    chk_reg("rst_tma", 2'd2, 8'h00);
    chk_reg("rst_tac", 2'd3, 8'hF8);
    chk("rst_irq", {7'b0, irq_timer}, 8'h00);
    chk("rst_taps", {2'b0, div_taps}, 8'h00);
    reset = 1'b0;

    repeat (1024) step();
    chk_reg("t1_div", 2'd0, 8'h10);
    chk_reg("t1_tima", 2'd1, 8'h00);
    chk("t1_taps", {2'b0, div_taps}, 8'h00);

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].do_wr) wr(vecs[i].wr_addr, vecs[i].wr_data, vecs[i].wr_sel);
      rd(vecs[i].rd_addr, vecs[i].rd_sel, vecs[i].rd_en, v);
      chk(vecs[i].name, v, vecs[i].exp);
    end
    chk("t1_irq_none", irq_cnt[7:0], 8'd0);

    wr(2'd2, 8'hA5, 1'b1);
    wr(2'd0, 8'h00, 1'b1);
    wr(2'd1, 8'hF0, 1'b1);
    wr(2'd3, 8'h05, 1'b1);
    chk_reg("t2_start", 2'd1, 8'hF0);
    repeat (61) step();
    chk_reg("t2_ff", 2'd1, 8'hFF);
    step();
    chk_reg("t2_ovf", 2'd1, 8'h00);
    chk("t2_ovf_irq", {7'b0, irq_timer}, 8'h00);
    step();
    chk_reg("t2_reload", 2'd1, 8'hA5);
    chk("t2_reload_irq", {7'b0, irq_timer}, 8'h01);
    step();
    chk("t2_irq_off", {7'b0, irq_timer}, 8'h00);
    chk_reg("t2_after", 2'd1, 8'hA5);
    chk("t2_irq_cnt", irq_cnt[7:0], 8'd1);

    wr(2'd1, 8'hFF, 1'b1);
    chk_reg("t3_ff", 2'd1, 8'hFF);
    step();
    chk_reg("t3_ovf", 2'd1, 8'h00);
    wr(2'd1, 8'h33, 1'b1);
    chk_reg("t3_cancel", 2'd1, 8'h33);
    chk("t3_cancel_irq", {7'b0, irq_timer}, 8'h00);
    step();
    chk("t3_cancel_irq2", {7'b0, irq_timer}, 8'h00);
    chk_reg("t3_cancel_keep", 2'd1, 8'h33);
    chk("t3_irq_cnt1", irq_cnt[7:0], 8'd1);
    wr(2'd1, 8'hFF, 1'b1);
    step();
    step();
    chk("t3_rl_irq", {7'b0, irq_timer}, 8'h01);
    wr(2'd1, 8'h33, 1'b1);
    chk_reg("t3_rl_tima_wr", 2'd1, 8'hA5);
    wr(2'd1, 8'hFF, 1'b1);
    step();
    step();
    chk("t3_rl2_irq", {7'b0, irq_timer}, 8'h01);
    wr(2'd2, 8'h5C, 1'b1);
    chk_reg("t3_rl_tma_wr", 2'd1, 8'h5C);
    chk_reg("t3_tma", 2'd2, 8'h5C);
    chk("t3_irq_cnt", irq_cnt[7:0], 8'd3);

    wr(2'd3, 8'h04, 1'b1);
    chk_reg("t4_sel_glitch", 2'd1, 8'h5D);
    repeat (49) step();
    chk_reg("t4_div_pre", 2'd0, 8'h02);
    chk("t4_taps", {2'b0, div_taps}, 8'h20);
    chk_reg("t4_tima_pre", 2'd1, 8'h5D);
    wr(2'd0, 8'h55, 1'b1);
    chk_reg("t4_div_clr", 2'd0, 8'h00);
    chk_reg("t4_div_glitch", 2'd1, 8'h5E);

    wr(2'd3, 8'h05, 1'b1);
    step();
    chk_reg("t5_pre", 2'd1, 8'h5E);
    wr(2'd3, 8'h01, 1'b1);
    chk_reg("t5_glitch", 2'd1, 8'h5F);
    wr(2'd3, 8'h05, 1'b1);
    wr(2'd3, 8'h01, 1'b1);
    chk_reg("t5_no_glitch", 2'd1, 8'h5F);
    repeat (4) step();
    chk_reg("t5_disabled", 2'd1, 8'h5F);

    wr(2'd1, 8'hFF, 1'b1);
    wr(2'd3, 8'h05, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 16 && !found; i++) begin
      step();
      rd(2'd1, 1'b1, 1'b1, v);
      if (v == 8'h00) found = 1'b1;
    end
    chk("t6_reach_ovf", {7'b0, found}, 8'h01);
    reset = 1'b1;
    chk_reg("t6_div", 2'd0, 8'h00);
    chk_reg("t6_tima", 2'd1, 8'h00);
    chk_reg("t6_tma", 2'd2, 8'h00);
    chk_reg("t6_tac", 2'd3, 8'hF8);
    chk("t6_irq", {7'b0, irq_timer}, 8'h00);
    step();
    step();
    reset = 1'b0;
    repeat (300) step();
    chk("t6_irq_cnt", irq_cnt[7:0], 8'd3);
    chk_reg("t6_div_run", 2'd0, 8'h04);
    chk_reg("t6_tima_run", 2'd1, 8'h00);
    chk("irq_consecutive", irq_consec[7:0], 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
